// File: rtl/kbd_pkg.sv
// Shared types and constants for the keystroke scheduler.
// The optional shift-lead phase is enabled by defining KBD_SHIFT_LEAD_EN.
package kbd_pkg;

    // Width of the press/gap/lead down-counter.
    localparam int KBD_TMR_W = 22;

    // Bit of the matrix word that carries the shift key.
    localparam logic [15:0] KBD_SHIFT_MASK = 16'h8000;

    // Scheduler phases: waiting, shift-only lead-in, key held, all-released gap.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        PRESS = 2'd2,
        GAP   = 2'd3
    } kbd_state_t;

endpackage

// File: rtl/kbd_fifo.sv
// Synchronous first-word-fall-through FIFO that queues decoded matrix words.
// dout always shows the head entry; push/pop are ignored when full/empty.
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 16
)(
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [LW-1:0] r_level;

    logic w_pushEff;
    logic w_popEff;

    assign full      = (r_level == LW'(DEPTH));
    assign empty     = (r_level == '0);
    assign level     = r_level;
    assign dout      = r_mem[r_rdPtr];
    assign w_pushEff = push && !full;
    assign w_popEff  = pop && !empty;

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clk_in) begin
        if (w_pushEff) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two; clear empties the queue.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else if (clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_pushEff) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_popEff) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_pushEff, w_popEff})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/kbd_scheduler.sv
// Keystroke scheduler: queues matrix words and replays them onto the keyboard
// matrix register with a fixed hold time and release gap between keys.
// Define KBD_SHIFT_LEAD_EN to assert shift alone before each shifted key.
module kbd_scheduler
    import kbd_pkg::*;
#(
    parameter int                   FIFO_DEPTH  = 16,
    parameter logic [KBD_TMR_W-1:0] HOLD_CYCLES = 22'h280000,
    parameter logic [KBD_TMR_W-1:0] GAP_CYCLES  = 22'h100000,
    parameter logic [KBD_TMR_W-1:0] LEAD_CYCLES = 22'h040000
)(
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [15:0]                   key_data,
    input  logic                          key_stb,
    input  logic                          flush,
    output logic [15:0]                   kbd_reg,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

`ifdef KBD_SHIFT_LEAD_EN
    localparam bit C_LEAD_EN = 1'b1;
`else
    localparam bit C_LEAD_EN = 1'b0;
`endif

    localparam logic [KBD_TMR_W-1:0] C_ONE = KBD_TMR_W'(1);

    kbd_state_t           r_state;
    logic [KBD_TMR_W-1:0] r_tmr;
    logic [15:0]          r_kbdReg;
    logic [15:0]          r_latched;
    logic                 r_overflow;

    logic [15:0]          w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_keyValid;
    logic                 w_push;
    logic                 w_drop;
    logic                 w_pop;
    logic                 w_tmrZero;
    logic                 w_loadPoint;
    logic                 w_leadHead;
    kbd_state_t           w_loadState;
    logic [15:0]          w_loadKbd;
    logic [KBD_TMR_W-1:0] w_loadTmr;

    // A strobe counts only for a non-zero word; full is judged before the edge
    // so a pop in the same cycle never makes room, and flush drops everything.
    assign w_keyValid = key_stb && (key_data != 16'h0000);
    assign w_push     = w_keyValid && !w_full && !flush;
    assign w_drop     = w_keyValid && w_full && !flush;

    // The head is taken from IDLE, or straight from the last gap cycle.
    assign w_tmrZero   = (r_tmr == '0);
    assign w_loadPoint = (r_state == IDLE) || ((r_state == GAP) && w_tmrZero);
    assign w_pop       = w_loadPoint && !w_empty && !flush;

    // What a freshly popped word turns into: shift-only lead or a direct press.
    assign w_leadHead  = C_LEAD_EN && ((w_head & KBD_SHIFT_MASK) != 16'h0000);
    assign w_loadState = w_leadHead ? LEAD : PRESS;
    assign w_loadKbd   = w_leadHead ? KBD_SHIFT_MASK : w_head;
    assign w_loadTmr   = w_leadHead ? (LEAD_CYCLES - C_ONE) : (HOLD_CYCLES - C_ONE);

    assign kbd_reg  = r_kbdReg;
    assign overflow = r_overflow;
    assign busy     = (r_state != IDLE) || !w_empty;

    kbd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk_in (clk_in),
        .reset  (reset),
        .clear  (flush),
        .push   (w_push),
        .pop    (w_pop),
        .din    (key_data),
        .dout   (w_head),
        .level  (fifo_level),
        .full   (w_full),
        .empty  (w_empty)
    );

    // Phase sequencer: loads a popped key, then counts the lead, press and gap down.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_tmr      <= '0;
            r_kbdReg   <= 16'h0000;
            r_latched  <= 16'h0000;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_state    <= IDLE;
            r_tmr      <= '0;
            r_kbdReg   <= 16'h0000;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_state   <= w_loadState;
                r_kbdReg  <= w_loadKbd;
                r_tmr     <= w_loadTmr;
                r_latched <= w_head;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    LEAD: begin
                        if (w_tmrZero) begin
                            r_kbdReg <= r_latched;
                            r_tmr    <= HOLD_CYCLES - C_ONE;
                            r_state  <= PRESS;
                        end else begin
                            r_tmr <= r_tmr - C_ONE;
                        end
                    end
                    PRESS: begin
                        if (w_tmrZero) begin
                            r_kbdReg <= 16'h0000;
                            r_tmr    <= GAP_CYCLES - C_ONE;
                            r_state  <= GAP;
                        end else begin
                            r_tmr <= r_tmr - C_ONE;
                        end
                    end
                    GAP: begin
                        if (w_tmrZero) begin
                            r_state <= IDLE;
                        end else begin
                            r_tmr <= r_tmr - C_ONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
